pwm_capture: RTL and testbench

- Receive-side counterpart of the center-aligned complementary PWM generator.
- Samples an incoming high-side/low-side gate pair, decodes per-period on-times, period and deadtime, and flags shoot-through.
- Sits on the feedback/monitor path of the motor drive; used for gate-signal self-check and closed-loop duty verification.

---
 rtl/pwm_pkg.sv | 37 +++
 rtl/pwm_input_sync.sv | 41 ++++
 rtl/pwm_capture.sv | 199 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared definitions for the PWM capture path: capture state
//            encoding, per-cycle gate-pair class codes, default counter width
//            and the generator constants, so both ends of the link agree.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Default counter width: one full 12-bit up/down period fits.
    localparam int c_CNT_WIDTH = 14;

    // Generator-side constants (center-aligned complementary PWM).
    localparam int c_PWM_WIDTH    = 12;
    localparam int c_PWM_DEADTIME = 30;

    typedef enum logic [0:0] {
        ST_SYNC    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Class code is the {hs, ls} pair itself, so decoding is a plain cast.
    typedef enum logic [1:0] {
        CLS_DEAD  = 2'b00,
        CLS_LOW   = 2'b01,
        CLS_HIGH  = 2'b10,
        CLS_FAULT = 2'b11
    } cls_t;

    function automatic cls_t f_classify(input logic hs, input logic ls);
        return cls_t'({hs, ls});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_input_sync.sv
`default_nettype none
// ============================================================================
// Module   : pwm_input_sync
// Purpose  : Multi-flop synchronizer for one asynchronous bit followed by a
//            rising-edge detector.
// Ports    : i_clk    - system clock
//            i_reset  - synchronous active-high reset
//            i_async  - asynchronous input bit
//            o_level  - synchronized level
//            o_rise   - one-cycle pulse on a synchronized 0->1 transition
// Params   : SYNC_STAGES - synchronizer depth, minimum 2
// Revision : 1.0 - initial release
// ============================================================================
module pwm_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Receive-side decoder for a complementary high/low gate pair.
//            Measures per-period high-only, low-only and total cycle counts
//            (period boundary = high-side rising edge), optional both-off
//            count, saturation timeout and a sticky shoot-through flag.
// Macro    : PWM_CAPTURE_DEADTIME_EN - builds the dead-cycle counter;
//            when undefined o_deadtime is tied to 0.
// Ports    : i_clk, i_reset      - clock, synchronous active-high reset
//            i_pwm_high/low      - asynchronous gate signals
//            i_fault_clear       - clears o_fault
//            o_high_cnt/low_cnt  - high-only / low-only cycles, last period
//            o_period            - total cycles, last period
//            o_deadtime          - both-off cycles, last period
//            o_valid             - pulse when count outputs update
//            o_locked            - measuring
//            o_timeout           - period counter saturated
//            o_fault             - sticky shoot-through flag
// Params   : CNT_WIDTH, SYNC_STAGES
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH   = c_CNT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pwm_high,
    input  logic                 i_pwm_low,
    input  logic                 i_fault_clear,
    output logic [CNT_WIDTH-1:0] o_high_cnt,
    output logic [CNT_WIDTH-1:0] o_low_cnt,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_deadtime,
    output logic                 o_valid,
    output logic                 o_locked,
    output logic                 o_timeout,
    output logic                 o_fault
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
    endfunction

    logic w_hs;
    logic w_ls;
    logic w_hs_rise;
    logic w_ls_rise_unused;
    cls_t w_cls;

    pwm_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_high (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_pwm_high),
        .o_level (w_hs),
        .o_rise  (w_hs_rise)
    );

    pwm_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_low (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_pwm_low),
        .o_level (w_ls),
        .o_rise  (w_ls_rise_unused)
    );

    assign w_cls = f_classify(w_hs, w_ls);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] r_low;
    logic [CNT_WIDTH-1:0] r_period_out;
    logic [CNT_WIDTH-1:0] r_high_out;
    logic [CNT_WIDTH-1:0] r_low_out;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 r_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_SYNC;
            r_period     <= '0;
            r_high       <= '0;
            r_low        <= '0;
            r_period_out <= '0;
            r_high_out   <= '0;
            r_low_out    <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // A new shoot-through cycle takes priority over the clear request.
            if (w_cls == CLS_FAULT) begin
                r_fault <= 1'b1;
            end else if (i_fault_clear) begin
                r_fault <= 1'b0;
            end

            case (r_state)
                ST_SYNC: begin
                    // Edge cycle is the first cycle of the new period; the
                    // high side is on, so it can only be HIGH or FAULT.
                    if (w_hs_rise) begin
                        r_state  <= ST_MEASURE;
                        r_period <= c_CNT_ONE;
                        r_high   <= (w_cls == CLS_HIGH) ? c_CNT_ONE : '0;
                        r_low    <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_hs_rise) begin
                        r_period_out <= r_period;
                        r_high_out   <= r_high;
                        r_low_out    <= r_low;
                        r_valid      <= 1'b1;
                        r_timeout    <= 1'b0;
                        r_period     <= c_CNT_ONE;
                        r_high       <= (w_cls == CLS_HIGH) ? c_CNT_ONE : '0;
                        r_low        <= '0;
                    end else if (r_period == c_CNT_MAX) begin
                        // Saturated without a closing edge: drop lock and
                        // keep the last reported counts.
                        r_state   <= ST_SYNC;
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_high    <= '0;
                        r_low     <= '0;
                    end else begin
                        r_period <= f_sat_inc(r_period);
                        if (w_cls == CLS_HIGH) begin
                            r_high <= f_sat_inc(r_high);
                        end
                        if (w_cls == CLS_LOW) begin
                            r_low <= f_sat_inc(r_low);
                        end
                    end
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

`ifdef PWM_CAPTURE_DEADTIME_EN
    logic [CNT_WIDTH-1:0] r_dead;
    logic [CNT_WIDTH-1:0] r_dead_out;

    // Follows the same period boundaries as the main counters above.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dead     <= '0;
            r_dead_out <= '0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    r_dead <= '0;
                end
                ST_MEASURE: begin
                    if (w_hs_rise) begin
                        r_dead_out <= r_dead;
                        r_dead     <= '0;
                    end else if (r_period == c_CNT_MAX) begin
                        r_dead <= '0;
                    end else if (w_cls == CLS_DEAD) begin
                        r_dead <= f_sat_inc(r_dead);
                    end
                end
                default: begin
                    r_dead <= '0;
                end
            endcase
        end
    end

    assign o_deadtime = r_dead_out;
`else
    assign o_deadtime = '0;
`endif

    assign o_high_cnt = r_high_out;
    assign o_low_cnt  = r_low_out;
    assign o_period   = r_period_out;
    assign o_valid    = r_valid;
    assign o_locked   = (r_state == ST_MEASURE);
    assign o_timeout  = r_timeout;
    assign o_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Self-checking bench for pwm_capture: table of gate patterns,
//            randomized patterns against an arithmetic reference model, and
//            hand-written sequences for timeout, fault and mid-period reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int c_W   = 14;
    localparam int c_MAX = (1 << c_W) - 1;
`ifdef PWM_CAPTURE_DEADTIME_EN
    localparam bit c_DEAD_EN = 1'b1;
`else
    localparam bit c_DEAD_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           i_reset = 1'b0;
    logic           i_pwm_high = 1'b0;
    logic           i_pwm_low = 1'b0;
    logic           i_fault_clear = 1'b0;
    logic [c_W-1:0] o_high_cnt;
    logic [c_W-1:0] o_low_cnt;
    logic [c_W-1:0] o_period;
    logic [c_W-1:0] o_deadtime;
    logic           o_valid;
    logic           o_locked;
    logic           o_timeout;
    logic           o_fault;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_WIDTH(c_W), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_pwm_high    (i_pwm_high),
        .i_pwm_low     (i_pwm_low),
        .i_fault_clear (i_fault_clear),
        .o_high_cnt    (o_high_cnt),
        .o_low_cnt     (o_low_cnt),
        .o_period      (o_period),
        .o_deadtime    (o_deadtime),
        .o_valid       (o_valid),
        .o_locked      (o_locked),
        .o_timeout     (o_timeout),
        .o_fault       (o_fault)
    );

    typedef struct {
        int high;
        int low;
        int period;
        int dead;
    } rec_t;

    typedef struct {
        int h, d1, l, d2;      // stimulus: segment lengths of one period
        int eh, el, ep, ed;    // expected outputs (ed = dead total with feature)
    } vec_t;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Every o_valid pulse is captured mid-cycle for later comparison.
    always @(negedge clk) begin
        if (o_valid) begin
            q.push_back('{int'(o_high_cnt), int'(o_low_cnt), int'(o_period), int'(o_deadtime)});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a period of h/d1/l/d2 cycles reports plain sums.
    function automatic rec_t model(input int h, input int d1, input int l, input int d2);
        rec_t r;
        r.high   = h;
        r.low    = l;
        r.period = h + d1 + l + d2;
        r.dead   = c_DEAD_EN ? (d1 + d2) : 0;
        return r;
    endfunction

    task automatic seg(input logic hs, input logic ls, input int n);
        for (int k = 0; k < n; k++) begin
            i_pwm_high = hs;
            i_pwm_low  = ls;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic one_period(input int h, input int d1, input int l, input int d2);
        seg(1'b1, 1'b0, h);
        seg(1'b0, 1'b0, d1);
        seg(1'b0, 1'b1, l);
        seg(1'b0, 1'b0, d2);
    endtask

    // Closing edge plus enough idle cycles for it to cross the synchronizer.
    task automatic close_edge();
        seg(1'b1, 1'b0, 1);
        seg(1'b0, 1'b0, 6);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        seg(1'b0, 1'b0, 3);
        i_reset = 1'b0;
        seg(1'b0, 1'b0, 2);
        q.delete();
    endtask

    task automatic check_rec(input string name, input rec_t a, input rec_t e);
        check({name, ".high"},   a.high,   e.high);
        check({name, ".low"},    a.low,    e.low);
        check({name, ".period"}, a.period, e.period);
        check({name, ".dead"},   a.dead,   e.dead);
    endtask

    task automatic run_pattern(input string name, input int h, input int d1,
                               input int l, input int d2, input int nper, input rec_t e);
        do_reset();
        for (int p = 0; p < nper; p++) begin
            one_period(h, d1, l, d2);
        end
        close_edge();
        // First edge only locks, so nper edges after it give nper reports.
        check({name, ".nvalid"}, q.size(), nper);
        for (int p = 0; p < q.size(); p++) begin
            check_rec(name, q[p], e);
        end
    endtask

    vec_t tbl[4];
    rec_t e;
    rec_t nominal;
    int   n;
    int   h, d1, l, d2;

    initial begin
        #1;
        // Generator at input 2048, WIDTH=12, DEADTIME=30: high-only time is
        // 2*(2048-DEADTIME-1), both slopes contribute 3*DEADTIME dead cycles.
        tbl[0] = '{100, 10, 200, 20, 100, 200, 330, 30};
        tbl[1] = '{1, 0, 1, 0, 1, 1, 2, 0};
        tbl[2] = '{5, 3, 7, 1, 5, 7, 16, 4};
        tbl[3] = '{2 * (2048 - c_PWM_DEADTIME - 1), c_PWM_DEADTIME,
                   2 * ((1 << c_PWM_WIDTH) - 2) - 2 * (2048 - c_PWM_DEADTIME - 1) - 3 * c_PWM_DEADTIME,
                   2 * c_PWM_DEADTIME,
                   4034, 4064, 8188, 90};
        nominal = model(100, 10, 200, 20);

        // Reset state
        i_reset = 1'b1;
        seg(1'b0, 1'b0, 3);
        check("rst.high",    int'(o_high_cnt), 0);
        check("rst.low",     int'(o_low_cnt),  0);
        check("rst.period",  int'(o_period),   0);
        check("rst.dead",    int'(o_deadtime), 0);
        check("rst.flags",   int'({o_valid, o_locked, o_timeout, o_fault}), 0);
        i_reset = 1'b0;

        // Table-driven patterns
        for (int t = 0; t < 4; t++) begin
            e.high   = tbl[t].eh;
            e.low    = tbl[t].el;
            e.period = tbl[t].ep;
            e.dead   = c_DEAD_EN ? tbl[t].ed : 0;
            run_pattern($sformatf("tbl%0d", t), tbl[t].h, tbl[t].d1, tbl[t].l, tbl[t].d2,
                        (t == 3) ? 2 : 3, e);
            check($sformatf("tbl%0d.locked", t), int'(o_locked), 1);
        end

        // Randomized patterns against the model
        for (int t = 0; t < 6; t++) begin
            h  = $urandom_range(200, 1);
            d1 = $urandom_range(20, 0);
            l  = $urandom_range(200, 1);
            d2 = $urandom_range(20, 0);
            run_pattern($sformatf("rnd%0d", t), h, d1, l, d2, 3, model(h, d1, l, d2));
        end

        // Timeout: lock, report two periods, then hold with no further edge
        do_reset();
        one_period(100, 10, 200, 20);
        one_period(100, 10, 200, 20);
        seg(1'b1, 1'b0, 1);
        n = 0;
        while (!o_timeout && n < 20000) begin
            seg(1'b0, 1'b0, 1);
            n++;
        end
        total++;
        if (n < c_MAX || n > c_MAX + 6) begin
            bad++;
            $display("FAIL to.latency: got %0d cycles expected %0d..%0d", n, c_MAX, c_MAX + 6);
        end
        check("to.timeout", int'(o_timeout), 1);
        check("to.locked",  int'(o_locked),  0);
        check("to.nvalid",  q.size(), 2);
        check_rec("to.hold", '{int'(o_high_cnt), int'(o_low_cnt), int'(o_period), int'(o_deadtime)},
                  nominal);
        one_period(100, 10, 200, 20);
        check("to.sticky",  int'(o_timeout), 1);
        close_edge();
        check("to.cleared", int'(o_timeout), 0);
        check("to.relock",  int'(o_locked),  1);
        check("to.nvalid2", q.size(), 3);
        if (q.size() == 3) check_rec("to.after", q[2], nominal);

        // Shoot-through for 3 cycles inside the high phase
        do_reset();
        check("flt.init", int'(o_fault), 0);
        one_period(100, 10, 200, 20);
        seg(1'b1, 1'b0, 50);
        seg(1'b1, 1'b1, 3);
        seg(1'b1, 1'b0, 47);
        seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 200);
        seg(1'b0, 1'b0, 20);
        close_edge();
        check("flt.set",    int'(o_fault), 1);
        check("flt.nvalid", q.size(), 2);
        if (q.size() == 2) check_rec("flt.period", q[1], '{97, 200, 330, c_DEAD_EN ? 30 : 0});
        seg(1'b0, 1'b0, 20);
        check("flt.sticky", int'(o_fault), 1);
        i_fault_clear = 1'b1;
        seg(1'b0, 1'b0, 1);
        i_fault_clear = 1'b0;
        seg(1'b0, 1'b0, 1);
        check("flt.clear",  int'(o_fault), 0);

        // Clear held across a single shoot-through cycle: set must win
        i_fault_clear = 1'b1;
        seg(1'b1, 1'b1, 1);
        seg(1'b0, 1'b0, 2);
        i_fault_clear = 1'b0;
        seg(1'b0, 1'b0, 2);
        check("flt.setwins", int'(o_fault), 1);
        i_fault_clear = 1'b1;
        seg(1'b0, 1'b0, 1);
        i_fault_clear = 1'b0;
        seg(1'b0, 1'b0, 1);
        check("flt.clear2", int'(o_fault), 0);

        // Reset pulse 150 cycles into a period
        do_reset();
        one_period(100, 10, 200, 20);
        seg(1'b1, 1'b0, 100);
        seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 40);
        check("mid.nvalid0", q.size(), 1);
        i_reset = 1'b1;
        seg(1'b0, 1'b1, 1);
        i_reset = 1'b0;
        check("mid.counts", int'(o_high_cnt) + int'(o_low_cnt) + int'(o_period) + int'(o_deadtime), 0);
        check("mid.flags",  int'({o_valid, o_locked, o_timeout, o_fault}), 0);
        seg(1'b0, 1'b1, 159);
        seg(1'b0, 1'b0, 20);
        one_period(100, 10, 200, 20);
        check("mid.nvalid1", q.size(), 1);
        close_edge();
        check("mid.nvalid2", q.size(), 2);
        if (q.size() == 2) check_rec("mid.after", q[1], nominal);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
